ycbcr444_2_rgb888: RTL and testbench
====================================

# ycbcr444_2_rgb888

- Converts a YCbCr 4:4:4 pixel stream (8 bits per component, limited range) into RGB888.
- Sits directly downstream of the 4:2:2→4:4:4 chroma upsampler and consumes its y/cb/cr outputs and its sync and DE outputs unchanged.
- A fixed 3-stage pipeline accepts one pixel per clock with no stalls.
- Sync and DE are delayed by exactly the datapath latency so RGB stays aligned to timing.

## Interface
Parameters:
- LATENCY, 3, pipeline depth; fixed, not user-overridable (documented for integrators).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset: rst_n, asynchronous, active-low; clock clk
- i_v_sync  in  1  vertical sync, any polarity, passed through
- i_h_sync  in  1  horizontal sync, any polarity, passed through
- i_de  in  1  data enable; pixel valid when high
- y_in  in  8  luma, nominal 16..235
- cb_in  in  8  blue-difference chroma, nominal 16..240
- cr_in  in  8  red-difference chroma, nominal 16..240
- o_v_sync  out  1  i_v_sync delayed 3 clk
- o_h_sync  out  1  i_h_sync delayed 3 clk
- o_de  out  1  i_de delayed 3 clk
- r_out  out  8  red
- g_out  out  8  green
- b_out  out  8  blue

## Operation
- Stage 1 computes the offsets and products:
  - y' = Y−16, cb' = Cb−128, cr' = Cr−128, each signed 9 bit.
  - Registers five signed 18-bit products: Ky·y', Krv·cr', Kgu·cb', Kgv·cr', Kbu·cb'.
- Stage 2 registers three signed 20-bit sums:
  - R = Ky·y' + Krv·cr'
  - G = Ky·y' − Kgu·cb' − Kgv·cr'
  - B = Ky·y' + Kbu·cb'
- Stage 3 produces each output channel:
  - Adds 128, then arithmetic shift right by 8 (round, floor on negatives).
  - Saturates to 0..255.
  - Registers the result when de_d2 is high; otherwise registers 0, so blanking outputs black.
- Coefficients are scaled ×256 (BT.601 default): Ky=298, Krv=409, Kgu=100, Kgv=208, Kbu=516.
- The datapath runs every clock regardless of DE. DE only gates the final output register.
- Out-of-range inputs (Y<16, Y>235, C>240) are legal and must saturate. There is no wrap-around.
- Sync polarity is not interpreted. Sync and DE are pure 3-deep shift registers.

## Timing
- Reset: all pipeline registers and all outputs (o_v_sync, o_h_sync, o_de, r_out, g_out, b_out) are 0.
- Latency: input sampled at edge n appears on the outputs after edge n+3, for data, syncs and DE alike.
- Throughput: 1 pixel/clk, sustained indefinitely. There is no ready/valid handshake and no backpressure.
- DE falling edge: last pixel out at n+3. At n+4 RGB=0 and o_de=0 together.
- DE toggling every cycle: each pixel and each blank slot is preserved 1:1.
- Reset asserted mid-line: outputs go to 0 immediately (asynchronous). After release, the first valid pixel appears 3 clk after the first sampled i_de=1. No stale pixel from before reset may appear.
- Reset release is synchronised externally. The block has no reset synchroniser.

## Configuration
- YCBCR2RGB_BT709_EN, defined: BT.709 coefficients Ky=298, Krv=459, Kgu=55, Kgv=136, Kbu=541.
- YCBCR2RGB_BT709_EN, undefined: BT.601 coefficients as listed in Operation.
- Pipeline structure, latency, widths and ports are identical in both builds.

## Structure
- Shared package ycbcr_pkg holds:
  - Both coefficient sets as localparams.
  - Offsets Y_OFS=16 and C_OFS=128.
  - Widths: PROD_W=18, SUM_W=20, ROUND=128, SHIFT=8.
- Sub-module rgb_round_sat8 performs the stage-3 add 128, shift and clamp 0..255 on a signed 20-bit input. It is instantiated three times.
- The sync/DE delay line stays inline.

## Test plan
- Reset with inputs toggling → all outputs 0 during reset. After release with i_de=0 → RGB=0, o_de=0.
- White Y=235, Cb=Cr=128, DE high at cycle 0 → at cycle 3: RGB=(255,255,255), o_de=1. Black Y=16 → (0,0,0).
- BT.601 red Y=81, Cb=90, Cr=240 → (255,0,0). Saturation input Y=Cb=Cr=255 → (255,125,255). Underflow input Y=0, Cb=Cr=128 → (0,0,0).
- Y=16, Cb=128, Cr=240 → R=179 with the macro undefined; R=201 with YCBCR2RGB_BT709_EN defined; G=B=0 in both builds.
- 640-pixel line with random YCbCr, followed by blanking and sync pulses:
  - Each output matches the reference model 3 clk later.
  - o_h_sync/o_v_sync edges are exactly 3 clk after input edges.
  - RGB=0 whenever o_de=0.
- rst_n asserted at pixel 100 of an active line and released 5 clk later → no pre-reset pixel is emitted. The first output pixel is the first post-reset DE pixel, 3 clk later.

Source files
------------

// File: rtl/ycbcr_pkg.sv
// ycbcr_pkg: shared constants and types for ycbcr444_2_rgb888.
// Define YCBCR2RGB_BT709_EN to select the BT.709 coefficient set (BT.601 otherwise).
package ycbcr_pkg;
    localparam int LATENCY = 3;
    localparam int Y_OFS   = 16;
    localparam int C_OFS   = 128;
    localparam int PROD_W  = 18;
    localparam int SUM_W   = 20;
    localparam int ROUND   = 128;
    localparam int SHIFT   = 8;
    localparam int KY_601  = 298;
    localparam int KRV_601 = 409;
    localparam int KGU_601 = 100;
    localparam int KGV_601 = 208;
    localparam int KBU_601 = 516;
    localparam int KY_709  = 298;
    localparam int KRV_709 = 459;
    localparam int KGU_709 = 55;
    localparam int KGV_709 = 136;
    localparam int KBU_709 = 541;
`ifdef YCBCR2RGB_BT709_EN
    localparam int KY  = KY_709;
    localparam int KRV = KRV_709;
    localparam int KGU = KGU_709;
    localparam int KGV = KGV_709;
    localparam int KBU = KBU_709;
`else
    localparam int KY  = KY_601;
    localparam int KRV = KRV_601;
    localparam int KGU = KGU_601;
    localparam int KGV = KGV_601;
    localparam int KBU = KBU_601;
`endif
    typedef struct packed {
        logic v;
        logic h;
        logic de;
    } sync_t;
endpackage

// File: rtl/rgb_round_sat8.sv
// rgb_round_sat8: rounds a x256-scaled signed channel sum back to 8 bits and clamps it to 0..255.
module rgb_round_sat8
    import ycbcr_pkg::*;
(
    input  logic signed [SUM_W-1:0] sum_i,
    output logic        [7:0]       pix_o
);
    logic signed [SUM_W-1:0] sh;
    always_comb begin
        sh    = (sum_i + $signed(SUM_W'(ROUND))) >>> SHIFT;
        pix_o = sh[SUM_W-1] ? 8'd0 : (|sh[SUM_W-2:8]) ? 8'd255 : sh[7:0];
    end
endmodule

// File: rtl/ycbcr444_2_rgb888.sv
// ycbcr444_2_rgb888: 3-stage limited-range YCbCr 4:4:4 to RGB888 converter with aligned sync/DE.
// Coefficient set chosen by YCBCR2RGB_BT709_EN (see ycbcr_pkg).
module ycbcr444_2_rgb888
    import ycbcr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_v_sync,
    input  logic       i_h_sync,
    input  logic       i_de,
    input  logic [7:0] y_in,
    input  logic [7:0] cb_in,
    input  logic [7:0] cr_in,
    output logic       o_v_sync,
    output logic       o_h_sync,
    output logic       o_de,
    output logic [7:0] r_out,
    output logic [7:0] g_out,
    output logic [7:0] b_out
);
    localparam logic signed [PROD_W-1:0] K_Y  = PROD_W'(KY);
    localparam logic signed [PROD_W-1:0] K_RV = PROD_W'(KRV);
    localparam logic signed [PROD_W-1:0] K_GU = PROD_W'(KGU);
    localparam logic signed [PROD_W-1:0] K_GV = PROD_W'(KGV);
    localparam logic signed [PROD_W-1:0] K_BU = PROD_W'(KBU);

    logic signed [8:0]        y_ofs, cb_ofs, cr_ofs;
    logic signed [PROD_W-1:0] ky_y_q, krv_cr_q, kgu_cb_q, kgv_cr_q, kbu_cb_q;
    logic signed [SUM_W-1:0]  r_sum_q, g_sum_q, b_sum_q;
    logic [7:0]               r_sat, g_sat, b_sat;
    logic [7:0]               r_d, g_d, b_d, r_q, g_q, b_q;
    sync_t                    sync_q [LATENCY];

    always_comb begin
        y_ofs  = $signed({1'b0, y_in})  - $signed(9'(Y_OFS));
        cb_ofs = $signed({1'b0, cb_in}) - $signed(9'(C_OFS));
        cr_ofs = $signed({1'b0, cr_in}) - $signed(9'(C_OFS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ky_y_q   <= '0;
            krv_cr_q <= '0;
            kgu_cb_q <= '0;
            kgv_cr_q <= '0;
            kbu_cb_q <= '0;
            r_sum_q  <= '0;
            g_sum_q  <= '0;
            b_sum_q  <= '0;
        end else begin
            ky_y_q   <= y_ofs  * K_Y;
            krv_cr_q <= cr_ofs * K_RV;
            kgu_cb_q <= cb_ofs * K_GU;
            kgv_cr_q <= cr_ofs * K_GV;
            kbu_cb_q <= cb_ofs * K_BU;
            r_sum_q  <= SUM_W'(ky_y_q) + SUM_W'(krv_cr_q);
            g_sum_q  <= SUM_W'(ky_y_q) - SUM_W'(kgu_cb_q) - SUM_W'(kgv_cr_q);
            b_sum_q  <= SUM_W'(ky_y_q) + SUM_W'(kbu_cb_q);
        end
    end

    rgb_round_sat8 u_sat_r (.sum_i(r_sum_q), .pix_o(r_sat));
    rgb_round_sat8 u_sat_g (.sum_i(g_sum_q), .pix_o(g_sat));
    rgb_round_sat8 u_sat_b (.sum_i(b_sum_q), .pix_o(b_sat));

    // sync_q[1] is the DE that travels alongside the stage-2 sums; it blanks the final register
    always_comb begin
        r_d = sync_q[1].de ? r_sat : 8'd0;
        g_d = sync_q[1].de ? g_sat : 8'd0;
        b_d = sync_q[1].de ? b_sat : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '{default: '0};
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            sync_q[0] <= '{v: i_v_sync, h: i_h_sync, de: i_de};
            for (int i = 1; i < LATENCY; i++) sync_q[i] <= sync_q[i-1];
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
        end
    end

    assign o_v_sync = sync_q[LATENCY-1].v;
    assign o_h_sync = sync_q[LATENCY-1].h;
    assign o_de     = sync_q[LATENCY-1].de;
    assign r_out    = r_q;
    assign g_out    = g_q;
    assign b_out    = b_q;
endmodule

// File: tb/tb_ycbcr444_2_rgb888.sv
// tb_ycbcr444_2_rgb888: table vectors, random video line and reset-mid-line checks against an arithmetic reference.
module tb_ycbcr444_2_rgb888;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v_i = 1'b0, h_i = 1'b0, de_i = 1'b0;
    logic [7:0] y_i = '0, cb_i = '0, cr_i = '0;
    logic       v_o, h_o, de_o;
    logic [7:0] r_o, g_o, b_o;
    int         n_chk = 0;
    int         n_fail = 0;

`ifdef YCBCR2RGB_BT709_EN
    localparam int CY = 298, CRV = 459, CGU = 55, CGV = 136, CBU = 541;
    localparam logic [7:0] R_CR240 = 8'd201;
`else
    localparam int CY = 298, CRV = 409, CGU = 100, CGV = 208, CBU = 516;
    localparam logic [7:0] R_CR240 = 8'd179;
`endif

    typedef struct packed {
        logic v; logic h; logic de;
        logic [7:0] r; logic [7:0] g; logic [7:0] b;
    } px_t;

    typedef struct {
        logic [7:0] y, cb, cr, r, g, b;
        string      name;
    } vec_t;

    px_t q[$];

    ycbcr444_2_rgb888 dut (
        .clk(clk), .rst_n(rst_n),
        .i_v_sync(v_i), .i_h_sync(h_i), .i_de(de_i),
        .y_in(y_i), .cb_in(cb_i), .cr_in(cr_i),
        .o_v_sync(v_o), .o_h_sync(h_o), .o_de(de_o),
        .r_out(r_o), .g_out(g_o), .b_out(b_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] chan(int x);
        int f;
        f = (x + 128) / 256;
        if ((x + 128) < 0 && f * 256 != (x + 128)) f = f - 1;
        return (f < 0) ? 8'd0 : (f > 255) ? 8'd255 : 8'(f);
    endfunction

    function automatic px_t model(logic v, logic h, logic de, logic [7:0] y, logic [7:0] cb, logic [7:0] cr);
        px_t p;
        int yy, uu, vv;
        yy = int'(y) - 16;
        uu = int'(cb) - 128;
        vv = int'(cr) - 128;
        p.v = v; p.h = h; p.de = de;
        p.r = de ? chan(CY * yy + CRV * vv) : 8'd0;
        p.g = de ? chan(CY * yy - CGU * uu - CGV * vv) : 8'd0;
        p.b = de ? chan(CY * yy + CBU * uu) : 8'd0;
        return p;
    endfunction

    task automatic compare(string name, px_t e);
        n_chk++;
        if ({v_o, h_o, de_o, r_o, g_o, b_o} !== e) begin
            n_fail++;
            $display("FAIL %s: got v=%b h=%b de=%b rgb=(%0d,%0d,%0d) exp v=%b h=%b de=%b rgb=(%0d,%0d,%0d)",
                     name, v_o, h_o, de_o, r_o, g_o, b_o, e.v, e.h, e.de, e.r, e.g, e.b);
        end
    endtask

    task automatic pipe_reset();
        q.delete();
        q.push_back('0);
        q.push_back('0);
    endtask

    // called at a negedge: drive one pixel, advance one clock, check the output due now
    task automatic step(logic v, logic h, logic de, logic [7:0] y, logic [7:0] cb, logic [7:0] cr);
        px_t e;
        v_i = v; h_i = h; de_i = de; y_i = y; cb_i = cb; cr_i = cr;
        q.push_back(model(v, h, de, y, cb, cr));
        @(posedge clk);
        @(negedge clk);
        e = q.pop_front();
        compare("stream", e);
        if (!de_o) begin
            n_chk++;
            if ({r_o, g_o, b_o} !== 24'd0) begin
                n_fail++;
                $display("FAIL blank_black: got rgb=(%0d,%0d,%0d) exp (0,0,0)", r_o, g_o, b_o);
            end
        end
    endtask

    task automatic rnd_step(logic v, logic h, logic de);
        step(v, h, de, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{8'd235, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255, "white"};
        vt[1] = '{8'd16,  8'd128, 8'd128, 8'd0,   8'd0,   8'd0,   "black"};
        vt[2] = '{8'd81,  8'd90,  8'd240, 8'd255, 8'd0,   8'd0,   "red601"};
        vt[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd125, 8'd255, "sat"};
        vt[4] = '{8'd0,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0,   "underflow"};
        vt[5] = '{8'd16,  8'd128, 8'd240, R_CR240, 8'd0,  8'd0,   "cr240"};
`ifdef YCBCR2RGB_BT709_EN
        vt[2].r = 8'd255;
        vt[2].g = chan(CY * 65 - CGU * (-38) - CGV * 112);
        vt[2].b = chan(CY * 65 + CBU * (-38));
        vt[3].g = chan(CY * 239 - CGU * 127 - CGV * 127);
`endif
        // reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v_i = ~v_i; h_i = ~h_i; de_i = ~de_i;
            y_i = 8'($urandom); cb_i = 8'($urandom); cr_i = 8'($urandom);
            @(posedge clk); #1;
            compare("in_reset", '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pipe_reset();
        for (int i = 0; i < 4; i++) rnd_step(1'b0, 1'b0, 1'b0);

        // table vectors: each emerges exactly three clocks after it is driven
        foreach (vt[k]) begin
            step(1'b0, 1'b0, 1'b1, vt[k].y, vt[k].cb, vt[k].cr);
            rnd_step(1'b0, 1'b0, 1'b0);
            rnd_step(1'b0, 1'b0, 1'b0);
            compare(vt[k].name, '{v: 1'b0, h: 1'b0, de: 1'b1, r: vt[k].r, g: vt[k].g, b: vt[k].b});
        end

        // active line, blanking with h-sync pulse, then a v-sync pulse
        for (int i = 0; i < 640; i++) rnd_step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) rnd_step(1'b0, (i >= 5 && i < 10), 1'b0);
        for (int i = 0; i < 6; i++) rnd_step(1'b1, 1'b0, 1'b0);
        // DE toggling every cycle
        for (int i = 0; i < 40; i++) rnd_step(1'b0, 1'b0, 1'(i % 2));

        // reset asserted at pixel 100 of an active line
        for (int i = 0; i < 100; i++) rnd_step(1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        compare("async_reset", '0);
        for (int i = 0; i < 5; i++) begin
            de_i = 1'b1; y_i = 8'($urandom); cb_i = 8'($urandom); cr_i = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            compare("reset_hold", '0);
        end
        rst_n = 1'b1;
        pipe_reset();
        for (int i = 0; i < 50; i++) rnd_step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) rnd_step(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
